// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: handshake and DM bus bundle shared by dm_arbiter and its requesters.
// Signals: req/we/ctrl/addr/wdata/ack for ports 0 and 1, rdata and busy back to the
//          requesters, dm_wr/dm_ctrl/dm_addr/dm_wdata toward the DM, dm_rdata from it.
//          err0/err1 exist only when DM_ARB_ALIGN_CHK_EN is defined.
// Modports: slave = arbiter side, master = requesters plus DM side.
interface dm_arbiter_if;
    logic        req0, we0, ack0;
    logic [2:0]  ctrl0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1, ack1;
    logic [2:0]  ctrl1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata;
    logic        busy;
    logic        dm_wr;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
`ifdef DM_ARB_ALIGN_CHK_EN
    logic        err0, err1;
`endif
    modport slave (
        input  req0, we0, ctrl0, addr0, wdata0,
        input  req1, we1, ctrl1, addr1, wdata1,
        input  dm_rdata,
`ifdef DM_ARB_ALIGN_CHK_EN
        output err0, err1,
`endif
        output ack0, ack1, rdata, busy, dm_wr, dm_ctrl, dm_addr, dm_wdata
    );
    modport master (
        output req0, we0, ctrl0, addr0, wdata0,
        output req1, we1, ctrl1, addr1, wdata1,
        output dm_rdata,
`ifdef DM_ARB_ALIGN_CHK_EN
        input  err0, err1,
`endif
        input  ack0, ack1, rdata, busy, dm_wr, dm_ctrl, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter/sequencer in front of the byte-addressed data memory.
// Ports: clk, rst (synchronous, active-high); bus (dm_arbiter_if.slave) carrying the
//        port 0/1 request handshakes, rdata/busy, and the DM write/ctrl/addr/data bus.
// Parameters: RR_EN (1 round-robin, 0 fixed priority with port 0 winning), MEM_BYTES.
// Option macro: DM_ARB_ALIGN_CHK_EN adds err0/err1 and misalignment/range flagging.
// Each transaction runs IDLE (grant+latch) -> ACCESS (DM cycle) -> RESP (ack pulse).
module dm_arbiter #(
    parameter bit          RR_EN     = 1'b1,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic        r_last, r_win, r_err;
    logic        r_ack0, r_ack1, r_busy, r_dm_wr;
    logic [2:0]  r_dm_ctrl;
    logic [31:0] r_dm_addr, r_dm_wdata, r_rdata;
    logic        w_gnt1, w_we, w_bad;
    logic [2:0]  w_ctrl;
    logic [31:0] w_addr, w_wdata;

    // Port 1 wins when it asks alone, or on a tie when round-robin says port 0 went last.
    assign w_gnt1  = bus.req1 & (~bus.req0 | (RR_EN & ~r_last));
    assign w_we    = w_gnt1 ? bus.we1    : bus.we0;
    assign w_ctrl  = w_gnt1 ? bus.ctrl1  : bus.ctrl0;
    assign w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

`ifdef DM_ARB_ALIGN_CHK_EN
    logic        r_err0, r_err1;
    logic [32:0] w_end;
    // Address of the last byte touched; codes 000/011/100 count as one byte.
    assign w_end = {1'b0, w_addr} + (w_ctrl[1:0] == 2'b01 ? 33'd1 :
                                     w_ctrl[1:0] == 2'b10 ? 33'd3 : 33'd0);
    assign w_bad = ((w_ctrl == 3'b001 || w_ctrl == 3'b101) && w_addr[0])
                 || (w_ctrl == 3'b010 && w_addr[1:0] != 2'b00)
                 || (w_end >= 33'(MEM_BYTES));
    assign bus.err0 = r_err0;
    assign bus.err1 = r_err1;
`else
    assign w_bad = 1'b0;
    // Base build passes every address through, so the DM size drives no logic here.
    if (MEM_BYTES == 0) begin : g_no_dm
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_err      <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
            r_dm_wr    <= 1'b0;
            r_dm_ctrl  <= 3'b000;
            r_dm_addr  <= 32'd0;
            r_dm_wdata <= 32'd0;
            r_rdata    <= 32'd0;
`ifdef DM_ARB_ALIGN_CHK_EN
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        r_dm_wr    <= w_we & ~w_bad;
                        r_dm_ctrl  <= w_ctrl;
                        r_dm_addr  <= w_addr;
                        r_dm_wdata <= w_wdata;
                        r_err      <= w_bad;
                        r_win      <= w_gnt1;
                        r_last     <= w_gnt1;
                        r_busy     <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes and flagged transactions return zero instead of DM data.
                    r_rdata <= (r_dm_wr | r_err) ? 32'd0 : bus.dm_rdata;
                    r_dm_wr <= 1'b0;
                    r_ack0  <= ~r_win;
                    r_ack1  <= r_win;
`ifdef DM_ARB_ALIGN_CHK_EN
                    r_err0  <= r_err & ~r_win;
                    r_err1  <= r_err & r_win;
`endif
                    r_state <= RESP;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef DM_ARB_ALIGN_CHK_EN
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
`endif
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.dm_wr    = r_dm_wr;
    assign bus.dm_ctrl  = r_dm_ctrl;
    assign bus.dm_addr  = r_dm_addr;
    assign bus.dm_wdata = r_dm_wdata;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter, one round-robin instance with a DM model
// and one fixed-priority instance used for grant-ordering checks.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef DM_ARB_ALIGN_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    dm_arbiter_if rr_bus();
    dm_arbiter_if fp_bus();

    dm_arbiter #(.RR_EN(1'b1), .MEM_BYTES(1024)) u_rr (.clk(clk), .rst(rst), .bus(rr_bus));
    dm_arbiter #(.RR_EN(1'b0), .MEM_BYTES(1024)) u_fp (.clk(clk), .rst(rst), .bus(fp_bus));

    assign fp_bus.dm_rdata = 32'd0;

    // Byte-addressed DM model: synchronous writes, combinational sign/zero-extended reads.
    logic [7:0] mem [0:1026];

    function automatic logic dm_ok(input logic [2:0] c);
        return c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b100 || c == 3'b101;
    endfunction

    function automatic logic [31:0] dm_rd(input logic [2:0] c, input logic [31:0] a);
        logic [10:0] i;
        logic [31:0] w;
        i = a[10:0];
        w = (a < 32'd1024) ? {mem[i + 11'd3], mem[i + 11'd2], mem[i + 11'd1], mem[i]} : 32'd0;
        case (c)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    assign rr_bus.dm_rdata = dm_rd(rr_bus.dm_ctrl, rr_bus.dm_addr);

    always @(posedge clk) begin
        if (rr_bus.dm_wr && rr_bus.dm_addr < 32'd1024 && dm_ok(rr_bus.dm_ctrl)) begin
            mem[rr_bus.dm_addr[10:0]] <= rr_bus.dm_wdata[7:0];
            if (rr_bus.dm_ctrl[1:0] != 2'b00) mem[rr_bus.dm_addr[10:0] + 11'd1] <= rr_bus.dm_wdata[15:8];
            if (rr_bus.dm_ctrl[1:0] == 2'b10) begin
                mem[rr_bus.dm_addr[10:0] + 11'd2] <= rr_bus.dm_wdata[23:16];
                mem[rr_bus.dm_addr[10:0] + 11'd3] <= rr_bus.dm_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Every ack on the round-robin instance is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rr_bus.ack0 | rr_bus.ack1) begin
            if (sb.size() == 0) begin
                check("spurious_ack", {30'd0, rr_bus.ack1, rr_bus.ack0}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {30'd0, rr_bus.ack1, rr_bus.ack0}, mon_e.port ? 32'd2 : 32'd1);
                check("rdata", rr_bus.rdata, mon_e.data);
`ifdef DM_ARB_ALIGN_CHK_EN
                check("err", {30'd0, rr_bus.err1, rr_bus.err0},
                      mon_e.err ? (mon_e.port ? 32'd2 : 32'd1) : 32'd0);
`endif
            end
        end
    end

    task automatic drive(input logic p, input logic rq, input logic we, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            rr_bus.req1 = rq; rr_bus.we1 = we; rr_bus.ctrl1 = c; rr_bus.addr1 = a; rr_bus.wdata1 = d;
        end else begin
            rr_bus.req0 = rq; rr_bus.we0 = we; rr_bus.ctrl0 = c; rr_bus.addr0 = a; rr_bus.wdata0 = d;
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rr_bus.ack0 | rr_bus.ack1) && n < 20);
        if (!(rr_bus.ack0 | rr_bus.ack1)) check("ack_timeout", n, 32'd0);
    endtask

    task automatic txn(input logic p, input logic we, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                       output int lat);
        @(posedge clk); #1;
        drive(p, 1'b1, we, c, a, d);
        sb.push_back('{port: p, data: exp_d, err: exp_e});
        wait_ack(lat);
        drive(p, 1'b0, we, c, a, d);
    endtask

    task automatic check_reset_vals();
        check("rst_acks", {30'd0, rr_bus.ack1, rr_bus.ack0}, 32'd0);
        check("rst_busy", {31'd0, rr_bus.busy}, 32'd0);
        check("rst_dm_wr", {31'd0, rr_bus.dm_wr}, 32'd0);
        check("rst_dm_ctrl", {29'd0, rr_bus.dm_ctrl}, 32'd0);
        check("rst_dm_addr", rr_bus.dm_addr, 32'd0);
        check("rst_dm_wdata", rr_bus.dm_wdata, 32'd0);
        check("rst_rdata", rr_bus.rdata, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, a1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        fp_bus.req0 = 1'b0; fp_bus.we0 = 1'b0; fp_bus.ctrl0 = 3'b010; fp_bus.addr0 = 32'h0; fp_bus.wdata0 = 32'h0;
        fp_bus.req1 = 1'b0; fp_bus.we1 = 1'b0; fp_bus.ctrl1 = 3'b010; fp_bus.addr1 = 32'h4; fp_bus.wdata1 = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals();

        txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, n);
        check("wr_latency", n, 32'd3);
        txn(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, n);
        check("rd_latency", n, 32'd3);

        txn(1'b1, 1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0, 1'b0, n);
        txn(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, n);
        txn(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, n);
        txn(1'b0, 1'b1, 3'b001, 32'h30, 32'h00008001, 32'h0, 1'b0, n);
        txn(1'b1, 1'b0, 3'b001, 32'h30, 32'h0, 32'hFFFF8001, 1'b0, n);
        txn(1'b0, 1'b0, 3'b101, 32'h30, 32'h0, 32'h00008001, 1'b0, n);
        txn(1'b1, 1'b1, 3'b001, 32'h3FE, 32'h00005A5A, 32'h0, 1'b0, n);
        txn(1'b0, 1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00005A5A, 1'b0, n);

        txn(1'b0, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b0, n);
        check("ctrl_pass", {29'd0, rr_bus.dm_ctrl}, 32'd3);
        txn(1'b1, 1'b1, 3'b110, 32'h10, 32'h0, 32'h0, 1'b0, n);
        txn(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, n);
        txn(1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, ERR_EN, n);
        check("addr_pass", rr_bus.dm_addr, 32'h1000);

        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h11223344);
        @(posedge clk); #1;
        check("acc_dm_wr", {31'd0, rr_bus.dm_wr}, 32'd1);
        check("acc_busy", {31'd0, rr_bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check_reset_vals();
        repeat (4) @(negedge clk);
        check("rst_stays_idle", {31'd0, rr_bus.busy}, 32'd0);
        txn(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0, n);

        pulse_reset();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h80, 32'hA0A0A0A0);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h84, 32'hB1B1B1B1);
        for (int i = 0; i < 4; i++) sb.push_back('{port: i[0], data: 32'h0, err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            check(i == 0 ? "rr_first_lat" : "rr_gap", n, 32'd3);
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        txn(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'hA0A0A0A0, 1'b0, n);
        txn(1'b0, 1'b0, 3'b010, 32'h84, 32'h0, 32'hB1B1B1B1, 1'b0, n);

        @(posedge clk); #1;
        fp_bus.req0 = 1'b1;
        fp_bus.req1 = 1'b1;
        a0 = 0;
        a1 = 0;
        repeat (12) begin
            @(negedge clk);
            a0 += int'(fp_bus.ack0);
            a1 += int'(fp_bus.ack1);
        end
        check("fp_ack1_starved", a1, 32'd0);
        check("fp_ack0_count", a0, 32'd4);
        fp_bus.req0 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fp_bus.ack1 && n < 20);
        check("fp_ack1_lat", n, 32'd3);
        fp_bus.req1 = 1'b0;
        @(negedge clk);
        check("fp_ack1_single", {31'd0, fp_bus.ack1}, 32'd0);

`ifdef DM_ARB_ALIGN_CHK_EN
        txn(1'b0, 1'b1, 3'b010, 32'h42, 32'hAAAAAAAA, 32'h0, 1'b1, n);
        txn(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0, n);
        txn(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, n);
        txn(1'b1, 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1'b1, n);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer placed in front of the byte-addressed data memory (DM).
- Port 0 is the core load/store path; port 1 is a secondary master such as a program/data loader or debug port.
- Accepts one transaction at a time, latches it, drives the DM interface for exactly one access cycle, captures the asynchronous read data, then returns it with a one-cycle acknowledge.
- Round-robin or fixed priority, selected by parameter.

Parameters:
- RR_EN, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- MEM_BYTES, 1024: DM size in bytes; addresses at or above this are out of range.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 request; held until ack0
- we0  in  1  port 0 write (1) / read (0)
- ctrl0  in  3  port 0 size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- addr0  in  32  port 0 byte address
- wdata0  in  32  port 0 write data
- ack0  out  1  port 0 one-cycle completion pulse
- req1, we1, ctrl1, addr1, wdata1, ack1: same as port 0, for port 1
- rdata  out  32  read data, valid only in the cycle ack0 or ack1 is high
- busy  out  1  high in ACCESS and RESP states
- dm_wr  out  1  to DM write enable
- dm_ctrl  out  3  to DM control
- dm_addr  out  32  to DM address
- dm_wdata  out  32  to DM write data
- dm_rdata  in  32  from DM read data (combinational)

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, ack0/ack1 0, rdata 0, busy 0, dm_wr 0, dm_ctrl 000, dm_addr 0, dm_wdata 0, last-grant pointer 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If one req is high, grant it.
  - If both are high and RR_EN=1, grant the port not equal to the last-grant pointer. If RR_EN=0, grant port 0.
  - On grant: latch we/ctrl/addr/wdata into dm_* registers, record the winner, update the pointer, go to ACCESS.
- ACCESS:
  - dm_wr = latched we.
  - DM performs the write on the edge ending this cycle.
  - At that edge, capture dm_rdata into rdata for reads, or 0 for writes.
  - Go to RESP.
- RESP:
  - Assert ack of the winner for exactly one cycle; dm_wr = 0; go to IDLE.
- Latency: req sampled high at edge ending cycle N → ACCESS in N+1 → ack in N+2. Next grant earliest at the edge ending N+3, giving a throughput of one access per 3 cycles.
- Outside ACCESS, dm_wr is always 0; dm_ctrl/dm_addr/dm_wdata hold their last latched values.
- Ctrl codes 011/110/111 are passed through unchanged. DM treats them as no-op writes and reads 0; the transaction still acks.
- Addresses ≥ MEM_BYTES are passed through unchanged (no check in base build).
- req dropped before ack: the latched transaction still completes and acks; no retraction.
- req held high after ack: treated as a new request at the next IDLE.
- Reset during ACCESS: a write with dm_wr=1 still commits at that edge, since DM has no reset. Then all state returns to reset values and no ack is issued.
- Reset during RESP: ack is suppressed from the next cycle onward.
- ack0 and ack1 are never high simultaneously.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHK_EN.
- When defined:
  - Adds outputs err0 and err1, each 1 bit.
  - In IDLE, the granted transaction is flagged if any of these hold:
    - half access (001/101) at an odd address;
    - word access (010) with addr[1:0]≠00;
    - addr+size-1 ≥ MEM_BYTES.
  - A flagged transaction still goes through ACCESS with dm_wr forced to 0, and rdata is 0.
  - In RESP, err of the winner pulses together with ack.
- When undefined: err ports are absent and no checking is performed.

Test Plan:
- Single write then read, port 0:
  - Drive we0=1, ctrl0=010, addr0=0x10, wdata0=0xDEADBEEF.
  - ack0 arrives 2 cycles after the sampling edge.
  - Then read with ctrl0=010 → rdata=0xDEADBEEF with ack0.
- Simultaneous requests, RR_EN=1:
  - req0 and req1 both held high, each re-requesting after ack, for 4 transactions.
  - Required grant order: 0,1,0,1.
  - ack spacing is 3 cycles.
- Fixed priority, RR_EN=0:
  - req0 and req1 held continuously.
  - Port 1 receives no ack while req0 is held.
  - ack1 arrives 3 cycles after req0 drops.
- Signed/unsigned reads:
  - Preload byte 0x80 at addr 0x20.
  - ctrl 000 → rdata=0xFFFFFF80; ctrl 100 → rdata=0x00000080.
- Reset during ACCESS:
  - Assert rst in the ACCESS cycle of a write of 0x11223344 to 0x40.
  - No ack is issued and all outputs return to reset values.
  - A later word read of 0x40 returns 0x11223344.
- With DM_ARB_ALIGN_CHK_EN:
  - Word write to addr 0x42 → err0 and ack0 pulse together; memory at 0x40–0x43 is unchanged.
